// File: rtl/registers_bank_dumper.sv
// Snapshots the register-bank debug bus and streams it out byte by byte over valid/ready.
// Optional sync/count header before the data: define REGISTERS_BANK_DUMPER_HEADER_EN.
module registers_bank_dumper #(
    parameter int REGISTERS_BANK_SIZE = 32,
    parameter int REGISTERS_SIZE      = 32,
    parameter int BYTE_SIZE           = 8
) (
    input  logic                                          i_clk,
    input  logic                                          i_reset,
    input  logic                                          i_start,
    input  logic [REGISTERS_BANK_SIZE*REGISTERS_SIZE-1:0] i_bus_debug,
    input  logic                                          i_tx_ready,
    output logic [BYTE_SIZE-1:0]                          o_tx_data,
    output logic                                          o_tx_valid,
    output logic                                          o_busy,
    output logic                                          o_done
);

    localparam int BYTES_PER_REG = REGISTERS_SIZE / BYTE_SIZE;
    localparam int BYTE_CNT_W    = (BYTES_PER_REG > 1) ? $clog2(BYTES_PER_REG) : 1;
    localparam int REG_CNT_W     = (REGISTERS_BANK_SIZE > 1) ? $clog2(REGISTERS_BANK_SIZE) : 1;
    localparam int BANK_W        = REGISTERS_BANK_SIZE * REGISTERS_SIZE;

    localparam logic [REG_CNT_W-1:0]  LAST_REG  = REG_CNT_W'(REGISTERS_BANK_SIZE - 1);
    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_REG - 1);

`ifdef REGISTERS_BANK_DUMPER_HEADER_EN
    localparam logic [7:0] HDR_SYNC  = 8'hA5;
    localparam logic [7:0] HDR_COUNT = 8'(REGISTERS_BANK_SIZE);
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
`ifdef REGISTERS_BANK_DUMPER_HEADER_EN
        ST_HEADER,
`endif
        ST_SEND,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [BANK_W-1:0]       snapshot_q, snapshot_d;
    logic [REG_CNT_W-1:0]    reg_idx_q, reg_idx_d;
    logic [BYTE_CNT_W-1:0]   byte_idx_q, byte_idx_d;
    logic [BYTE_SIZE-1:0]    tx_data_q, tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
`ifdef REGISTERS_BANK_DUMPER_HEADER_EN
    logic                    hdr_idx_q, hdr_idx_d;
`endif

    // Byte-addressable view of the snapshot: snap_bytes[reg][byte], byte 0 = LSB.
    logic [BYTE_SIZE-1:0] snap_bytes [REGISTERS_BANK_SIZE][BYTES_PER_REG];

    genvar gi, gj;
    generate
        for (gi = 0; gi < REGISTERS_BANK_SIZE; gi++) begin : g_reg
            for (gj = 0; gj < BYTES_PER_REG; gj++) begin : g_byte
                assign snap_bytes[gi][gj] =
                    snapshot_q[gi*REGISTERS_SIZE + gj*BYTE_SIZE +: BYTE_SIZE];
            end
        end
    endgenerate

    logic                  transfer;
    logic                  byte_wrap;
    logic                  last_byte;
    logic [BYTE_CNT_W-1:0] nxt_byte;
    logic [REG_CNT_W-1:0]  nxt_reg;

    always_comb begin
        transfer  = tx_valid_q && i_tx_ready;
        byte_wrap = (byte_idx_q == LAST_BYTE);
        last_byte = byte_wrap && (reg_idx_q == LAST_REG);
        nxt_byte  = byte_wrap ? '0 : byte_idx_q + BYTE_CNT_W'(1);
        nxt_reg   = byte_wrap ? reg_idx_q + REG_CNT_W'(1) : reg_idx_q;
    end

    always_comb begin
        state_d    = state_q;
        snapshot_d = snapshot_q;
        reg_idx_d  = reg_idx_q;
        byte_idx_d = byte_idx_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
`ifdef REGISTERS_BANK_DUMPER_HEADER_EN
        hdr_idx_d  = hdr_idx_q;
`endif
        case (state_q)
            ST_IDLE: begin
                tx_valid_d = 1'b0;
                if (i_start) begin
                    snapshot_d = i_bus_debug;
                    reg_idx_d  = '0;
                    byte_idx_d = '0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_valid_d = 1'b1;
`ifdef REGISTERS_BANK_DUMPER_HEADER_EN
                tx_data_d  = BYTE_SIZE'(HDR_SYNC);
                hdr_idx_d  = 1'b0;
                state_d    = ST_HEADER;
`else
                tx_data_d  = snap_bytes[0][0];
                state_d    = ST_SEND;
`endif
            end
`ifdef REGISTERS_BANK_DUMPER_HEADER_EN
            ST_HEADER: begin
                // Counters stay at reg 0 / byte 0, so the data phase starts cleanly.
                if (transfer) begin
                    if (!hdr_idx_q) begin
                        tx_data_d = BYTE_SIZE'(HDR_COUNT);
                        hdr_idx_d = 1'b1;
                    end else begin
                        tx_data_d = snap_bytes[reg_idx_q][byte_idx_q];
                        state_d   = ST_SEND;
                    end
                end
            end
`endif
            ST_SEND: begin
                if (transfer) begin
                    if (last_byte) begin
                        tx_valid_d = 1'b0;
                        state_d    = ST_DONE;
                    end else begin
                        reg_idx_d  = nxt_reg;
                        byte_idx_d = nxt_byte;
                        tx_data_d  = snap_bytes[nxt_reg][nxt_byte];
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            snapshot_q <= '0;
            reg_idx_q  <= '0;
            byte_idx_q <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
`ifdef REGISTERS_BANK_DUMPER_HEADER_EN
            hdr_idx_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            snapshot_q <= snapshot_d;
            reg_idx_q  <= reg_idx_d;
            byte_idx_q <= byte_idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
`ifdef REGISTERS_BANK_DUMPER_HEADER_EN
            hdr_idx_q  <= hdr_idx_d;
`endif
        end
    end

    assign o_tx_data  = tx_data_q;
    assign o_tx_valid = tx_valid_q;
    assign o_busy     = (state_q != ST_IDLE);
    assign o_done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_registers_bank_dumper.sv
// Directed self-checking bench for registers_bank_dumper at default parameters.
module tb_registers_bank_dumper;

`ifdef REGISTERS_BANK_DUMPER_HEADER_EN
    localparam int HDR = 2;
`else
    localparam int HDR = 0;
`endif
    localparam int TOTAL = 32 * 4 + HDR;

    logic          clk;
    logic          i_reset;
    logic          i_start;
    logic [1023:0] i_bus_debug;
    logic          i_tx_ready;
    logic [7:0]    o_tx_data;
    logic          o_tx_valid;
    logic          o_busy;
    logic          o_done;

    int checks = 0;
    int errors = 0;

    logic [7:0] got [$];
    int         got_c [$];
    int         done_pulses;
    int         done_at;

    registers_bank_dumper dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_bus_debug (i_bus_debug),
        .i_tx_ready  (i_tx_ready),
        .o_tx_data   (o_tx_data),
        .o_tx_valid  (o_tx_valid),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected n-th byte of a dump when register j holds 32'hA0B0C000 | j.
    function automatic logic [7:0] exp_byte(input int n);
        int d;
        logic [31:0] v;
`ifdef REGISTERS_BANK_DUMPER_HEADER_EN
        if (n == 0) return 8'hA5;
        if (n == 1) return 8'h20;
`endif
        d = n - HDR;
        v = 32'hA0B0C000 | 32'(d / 4);
        return v[8*(d%4) +: 8];
    endfunction

    task automatic load_pattern();
        for (int j = 0; j < 32; j++) i_bus_debug[j*32 +: 32] = 32'hA0B0C000 | 32'(j);
    endtask

    task automatic do_start();
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    // Runs one dump to completion; mode 0 = ready always, mode 1 = ready 1,0,0 repeating.
    task automatic capture(input int mode, input int start_at, output bit timeout, output int unstable);
        bit prev_stall;
        logic [7:0] prev_data;
        got.delete();
        got_c.delete();
        done_pulses = 0;
        done_at     = -1;
        timeout     = 1'b1;
        unstable    = 0;
        prev_stall  = 1'b0;
        prev_data   = '0;
        for (int c = 0; c < 1000; c++) begin
            i_tx_ready = (mode == 0) ? 1'b1 : (c % 3 == 0);
            i_start    = (c == start_at);
            if (prev_stall && (o_tx_valid !== 1'b1 || o_tx_data !== prev_data)) unstable++;
            if (o_done === 1'b1) begin
                done_pulses++;
                if (done_pulses == 1) done_at = c;
            end
            if (done_pulses > 0 && c > done_at + 1) begin
                timeout = 1'b0;
                break;
            end
            if (o_tx_valid === 1'b1 && i_tx_ready) begin
                got.push_back(o_tx_data);
                got_c.push_back(c);
            end
            prev_stall = (o_tx_valid === 1'b1) && !i_tx_ready;
            prev_data  = o_tx_data;
            @(posedge clk); #1;
        end
        i_tx_ready = 1'b1;
        i_start    = 1'b0;
    endtask

    task automatic test_reset();
        i_reset    = 1'b0;
        i_start    = 1'b1;
        i_tx_ready = 1'b1;
        load_pattern();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({o_tx_data, o_tx_valid, o_busy, o_done} !== 11'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got data=%h valid=%b busy=%b done=%b, want all 0",
                         c, o_tx_data, o_tx_valid, o_busy, o_done);
            end
        end
        i_reset = 1'b1;
        i_start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            checks++;
            if (o_busy !== 1'b0 || o_tx_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_reset cycle %0d: got busy=%b valid=%b, want 0 0", c, o_busy, o_tx_valid);
            end
        end
        $display("test_reset done");
    endtask

    task automatic check_sequence(input string name);
        int bad;
        bad = 0;
        checks++;
        if (got.size() != TOTAL) begin
            errors++;
            $display("FAIL %s_count: got %0d transfers, want %0d", name, got.size(), TOTAL);
        end
        for (int i = 0; i < got.size() && i < TOTAL; i++)
            if (got[i] !== exp_byte(i)) begin
                if (bad < 4) $display("FAIL %s_byte[%0d]: got %h, want %h", name, i, got[i], exp_byte(i));
                bad++;
            end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_bytes: got %0d wrong bytes, want 0", name, bad);
        end
    endtask

    task automatic test_full_dump();
        bit to;
        int uns;
        int gaps;
        do_start();
        checks++;
        if (o_busy !== 1'b1 || o_tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_state: got busy=%b valid=%b, want 1 0", o_busy, o_tx_valid);
        end
        capture(0, -1, to, uns);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL full_timeout: got no o_done within budget, want completion");
        end
        check_sequence("full");
        checks++;
        if (got.size() == 0 || got_c[0] !== 1) begin
            errors++;
            $display("FAIL first_latency: got first transfer cycle %0d, want 1", got.size() ? got_c[0] : -1);
        end
        checks++;
        if (got.size() == 0 || got[got.size()-1] !== 8'hA0) begin
            errors++;
            $display("FAIL last_byte: got %h, want a0", got.size() ? got[got.size()-1] : 8'hxx);
        end
        gaps = 0;
        for (int i = 1; i < got_c.size(); i++) if (got_c[i] != got_c[i-1] + 1) gaps++;
        checks++;
        if (gaps != 0) begin
            errors++;
            $display("FAIL back_to_back: got %0d gaps between transfers, want 0", gaps);
        end
        checks++;
        if (done_pulses != 1 || got_c.size() == 0 || done_at != got_c[got_c.size()-1] + 1) begin
            errors++;
            $display("FAIL done_pulse: got %0d pulses at cycle %0d, want 1 at cycle %0d",
                     done_pulses, done_at, got_c.size() ? got_c[got_c.size()-1] + 1 : -1);
        end
        $display("test_full_dump done: %0d transfers", got.size());
    endtask

    task automatic test_backpressure();
        bit to;
        int uns;
        do_start();
        capture(1, -1, to, uns);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL bp_timeout: got no o_done within budget, want completion");
        end
        check_sequence("bp");
        checks++;
        if (uns != 0) begin
            errors++;
            $display("FAIL bp_stable: got %0d unstable stall cycles, want 0", uns);
        end
        checks++;
        if (done_pulses != 1) begin
            errors++;
            $display("FAIL bp_done: got %0d pulses, want 1", done_pulses);
        end
        $display("test_backpressure done: %0d transfers", got.size());
    endtask

    task automatic test_snapshot();
        bit to;
        int uns;
        do_start();
        i_bus_debug = {1024{1'b1}};
        capture(0, -1, to, uns);
        load_pattern();
        checks++;
        if (to) begin
            errors++;
            $display("FAIL snap_timeout: got no o_done within budget, want completion");
        end
        check_sequence("snap");
        $display("test_snapshot done: %0d transfers", got.size());
    endtask

    task automatic test_start_busy_reset();
        bit to;
        int uns;
        int n;
        bit saw_done;
        // Start pulse during SEND must be ignored.
        do_start();
        capture(0, 10, to, uns);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL busy_timeout: got no o_done within budget, want completion");
        end
        check_sequence("busy_start");
        // Abort mid-dump after 50 transfers.
        do_start();
        n = 0;
        for (int c = 0; c < 400 && n < 50; c++) begin
            if (o_tx_valid === 1'b1 && i_tx_ready) n++;
            @(posedge clk); #1;
        end
        checks++;
        if (n != 50) begin
            errors++;
            $display("FAIL abort_progress: got %0d transfers, want 50", n);
        end
        i_reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (o_tx_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs: got valid=%b busy=%b done=%b, want 0 0 0", o_tx_valid, o_busy, o_done);
        end
        i_reset  = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (o_done !== 1'b0 || o_busy !== 1'b0) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL abort_no_done: got done/busy activity after abort, want none");
        end
        do_start();
        capture(0, -1, to, uns);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL restart_timeout: got no o_done within budget, want completion");
        end
        check_sequence("restart");
        $display("test_start_busy_reset done: %0d transfers after restart", got.size());
    endtask

    initial begin
        i_reset     = 1'b0;
        i_start     = 1'b0;
        i_tx_ready  = 1'b1;
        i_bus_debug = '0;
        test_reset();
        test_full_dump();
        test_backpressure();
        test_snapshot();
        test_start_busy_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
